// File: rtl/axis_traffic_gen.sv
// AXI4-Stream counting-pattern source with an AXI4-Lite control slave.
// Drives a deterministic beat sequence so downstream counters can be checked.
module axis_traffic_gen #(
  parameter int DATA_WIDTH       = 8,
  parameter int STORE_DATA_WIDTH = 4,
  parameter int INITIAL_RUN      = 0
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst,
  input  logic                          s_axi_control_awvalid,
  output logic                          s_axi_control_awready,
  input  logic [15:0]                   s_axi_control_awaddr,
  input  logic                          s_axi_control_wvalid,
  output logic                          s_axi_control_wready,
  input  logic [STORE_DATA_WIDTH*8-1:0] s_axi_control_wdata,
  input  logic [STORE_DATA_WIDTH-1:0]   s_axi_control_wstrb,
  output logic                          s_axi_control_bvalid,
  input  logic                          s_axi_control_bready,
  output logic [1:0]                    s_axi_control_bresp,
  input  logic                          s_axi_control_arvalid,
  output logic                          s_axi_control_arready,
  input  logic [15:0]                   s_axi_control_araddr,
  output logic                          s_axi_control_rvalid,
  input  logic                          s_axi_control_rready,
  output logic [STORE_DATA_WIDTH*8-1:0] s_axi_control_rdata,
  output logic [1:0]                    s_axi_control_rresp,
  output logic [DATA_WIDTH*8-1:0]       outstream_tdata,
  output logic                          outstream_tvalid,
  input  logic                          outstream_tready
);

  localparam int TW = DATA_WIDTH * 8;

  localparam logic [15:0] ADDR_CTRL    = 16'h0010;
  localparam logic [15:0] ADDR_BEATS   = 16'h0014;
  localparam logic [15:0] ADDR_GAP     = 16'h0018;
  localparam logic [15:0] ADDR_SEED    = 16'h001C;
  localparam logic [15:0] ADDR_SENT_LO = 16'h0020;
  localparam logic [15:0] ADDR_SENT_HI = 16'h0024;
  localparam logic [15:0] ADDR_STATUS  = 16'h0028;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state_r, state_next_s;
  logic [31:0]   ctrl_r, beats_r, gap_r, seed_r;
  logic          ctrl_wr_r;
  logic [63:0]   sent_r, sent_next_s;
  logic [31:0]   sent_hi_shadow_r;
  logic [31:0]   pattern_r, pattern_next_s;
  logic [31:0]   run_cnt_r, run_next_s;
  logic [31:0]   gap_cnt_r, gap_next_s;
  logic          tvalid_r, tvalid_next_s;
  logic [TW-1:0] tdata_r, tdata_next_s;

  logic          aw_pend_r, w_pend_r;
  logic [15:0]   aw_addr_r;
  logic [31:0]   w_data_r;
  logic          commit_s;
  logic [15:0]   wr_addr_s;
  logic [31:0]   wr_data_s;
  logic          bvalid_r;

  logic          rvalid_r;
  logic [31:0]   rdata_r, rd_data_s;
  logic          ar_hs_s;
  logic          hs_s;
  logic          unused_s;

  assign unused_s = ^s_axi_control_wstrb;

  assign s_axi_control_awready = 1'b1;
  assign s_axi_control_wready  = 1'b1;
  assign s_axi_control_bresp   = 2'b00;
  assign s_axi_control_rresp   = 2'b00;
  assign s_axi_control_bvalid  = bvalid_r;
  assign s_axi_control_rvalid  = rvalid_r;
  assign s_axi_control_rdata   = rdata_r;
  assign s_axi_control_arready = !rvalid_r;
  assign outstream_tvalid      = tvalid_r;
  assign outstream_tdata       = tdata_r;

  // A write commits once both address and data are present, latched or live.
  assign commit_s  = (aw_pend_r || s_axi_control_awvalid) && (w_pend_r || s_axi_control_wvalid);
  assign wr_addr_s = aw_pend_r ? aw_addr_r : s_axi_control_awaddr;
  assign wr_data_s = w_pend_r ? w_data_r : s_axi_control_wdata;
  assign ar_hs_s   = s_axi_control_arvalid && !rvalid_r;
  assign hs_s      = tvalid_r && outstream_tready;

  // Write channel capture, register file and response.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      aw_pend_r <= 1'b0;
      aw_addr_r <= 16'h0000;
      w_pend_r  <= 1'b0;
      w_data_r  <= 32'h0000_0000;
      bvalid_r  <= 1'b0;
      ctrl_r    <= INITIAL_RUN[31:0];
      ctrl_wr_r <= 1'b0;
      beats_r   <= 32'h0000_0000;
      gap_r     <= 32'h0000_0000;
      seed_r    <= 32'h0000_0000;
    end else begin
      ctrl_wr_r <= 1'b0;
      if (commit_s) begin
        aw_pend_r <= aw_pend_r && s_axi_control_awvalid;
        w_pend_r  <= w_pend_r && s_axi_control_wvalid;
        bvalid_r  <= 1'b1;
        case (wr_addr_s)
          ADDR_CTRL: begin
            ctrl_r    <= wr_data_s;
            ctrl_wr_r <= 1'b1;
          end
          ADDR_BEATS: beats_r <= wr_data_s;
          ADDR_GAP:   gap_r   <= wr_data_s;
          ADDR_SEED:  seed_r  <= wr_data_s;
          default:    ;
        endcase
      end else begin
        aw_pend_r <= aw_pend_r || s_axi_control_awvalid;
        w_pend_r  <= w_pend_r || s_axi_control_wvalid;
        if (s_axi_control_bready) begin
          bvalid_r <= 1'b0;
        end
      end
      if (s_axi_control_awvalid) begin
        aw_addr_r <= s_axi_control_awaddr;
      end
      if (s_axi_control_wvalid) begin
        w_data_r <= s_axi_control_wdata;
      end
    end
  end

  // Read data mux.
  always_comb begin
    rd_data_s = 32'h0000_dead;
    case (s_axi_control_araddr)
      ADDR_CTRL:    rd_data_s = ctrl_r;
      ADDR_BEATS:   rd_data_s = beats_r;
      ADDR_GAP:     rd_data_s = gap_r;
      ADDR_SEED:    rd_data_s = seed_r;
      ADDR_SENT_LO: rd_data_s = sent_r[31:0];
      ADDR_SENT_HI: rd_data_s = sent_hi_shadow_r;
      ADDR_STATUS:  rd_data_s = {30'd0, state_r == DONE, (state_r == SEND) || (state_r == GAP)};
      default:      rd_data_s = 32'h0000_dead;
    endcase
  end

  // Registered read response; a SENT_LO read freezes the upper half for a coherent pair.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      rvalid_r         <= 1'b0;
      rdata_r          <= 32'h0000_0000;
      sent_hi_shadow_r <= 32'h0000_0000;
    end else if (ar_hs_s) begin
      rvalid_r <= 1'b1;
      rdata_r  <= rd_data_s;
      if (s_axi_control_araddr == ADDR_SENT_LO) begin
        sent_hi_shadow_r <= sent_r[63:32];
      end
    end else if (s_axi_control_rready) begin
      rvalid_r <= 1'b0;
    end
  end

  // Generator next-state and datapath.
  always_comb begin
    state_next_s   = state_r;
    pattern_next_s = pattern_r;
    run_next_s     = run_cnt_r;
    gap_next_s     = gap_cnt_r;
    sent_next_s    = sent_r;
    tdata_next_s   = tdata_r;
    case (state_r)
      IDLE: begin
        if (ctrl_r == 32'd1) begin
          pattern_next_s = seed_r;
          run_next_s     = 32'd0;
          state_next_s   = SEND;
        end else begin
          state_next_s = IDLE;
        end
      end
      SEND: begin
        if (hs_s) begin
          pattern_next_s = pattern_r + 32'd1;
          sent_next_s    = sent_r + 64'd1;
          run_next_s     = run_cnt_r + 32'd1;
          if (ctrl_r != 32'd1) begin
            state_next_s = IDLE;
          end else if ((beats_r != 32'd0) && (run_cnt_r + 32'd1 == beats_r)) begin
            state_next_s = DONE;
          end else if (gap_r != 32'd0) begin
            state_next_s = GAP;
            gap_next_s   = gap_r;
          end else begin
            state_next_s = SEND;
          end
        end else begin
          state_next_s = SEND;
        end
      end
      GAP: begin
        if (ctrl_r != 32'd1) begin
          state_next_s = IDLE;
        end else if (gap_cnt_r <= 32'd1) begin
          state_next_s = SEND;
        end else begin
          gap_next_s = gap_cnt_r - 32'd1;
        end
      end
      DONE: begin
        if (ctrl_r != 32'd1) begin
          state_next_s = IDLE;
        end else if (ctrl_wr_r) begin
          pattern_next_s = seed_r;
          run_next_s     = 32'd0;
          state_next_s   = SEND;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
    // Clear overrides any beat completing in the same cycle.
    if (ctrl_r == 32'd2) begin
      sent_next_s    = 64'd0;
      pattern_next_s = 32'd0;
    end else begin
      sent_next_s = sent_next_s;
    end
    tvalid_next_s = (state_next_s == SEND);
    // A stalled beat keeps its data; a new beat presents the updated pattern.
    if ((state_next_s == SEND) && !((state_r == SEND) && !hs_s)) begin
      tdata_next_s        = {TW{1'b0}};
      tdata_next_s[31:0]  = pattern_next_s;
    end else begin
      tdata_next_s = tdata_r;
    end
  end

  // Generator state registers.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_r   <= IDLE;
      pattern_r <= 32'd0;
      run_cnt_r <= 32'd0;
      gap_cnt_r <= 32'd0;
      sent_r    <= 64'd0;
      tvalid_r  <= 1'b0;
      tdata_r   <= {TW{1'b0}};
    end else begin
      state_r   <= state_next_s;
      pattern_r <= pattern_next_s;
      run_cnt_r <= run_next_s;
      gap_cnt_r <= gap_next_s;
      sent_r    <= sent_next_s;
      tvalid_r  <= tvalid_next_s;
      tdata_r   <= tdata_next_s;
    end
  end

endmodule

// File: tb/tb_axis_traffic_gen.sv
// Scoreboard bench for axis_traffic_gen: expected beats are queued when a run
// is launched and compared as the stream handshakes.
module tb_axis_traffic_gen;

  localparam logic [15:0] A_CTRL    = 16'h0010;
  localparam logic [15:0] A_BEATS   = 16'h0014;
  localparam logic [15:0] A_GAP     = 16'h0018;
  localparam logic [15:0] A_SEED    = 16'h001C;
  localparam logic [15:0] A_SENT_LO = 16'h0020;
  localparam logic [15:0] A_SENT_HI = 16'h0024;
  localparam logic [15:0] A_STATUS  = 16'h0028;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        awvalid = 1'b0, awready;
  logic [15:0] awaddr = 16'h0000;
  logic        wvalid = 1'b0, wready;
  logic [31:0] wdata = 32'h0;
  logic [3:0]  wstrb = 4'hf;
  logic        bvalid, bready = 1'b0;
  logic [1:0]  bresp, rresp;
  logic        arvalid = 1'b0, arready;
  logic [15:0] araddr = 16'h0000;
  logic        rvalid, rready = 1'b0;
  logic [31:0] rdata;
  logic [63:0] tdata;
  logic        tvalid;
  logic        tready = 1'b0;

  int          tests_run = 0;
  int          tests_failed = 0;
  int          cyc = 0;
  logic [63:0] exp_q[$];
  int          beat_cyc_q[$];
  logic [63:0] exp_sent = 64'd0;
  logic [31:0] rd;
  logic [31:0] rd_hi;
  int          n_before;
  int          n_sent;
  int          n;

  axis_traffic_gen #(.DATA_WIDTH(8), .STORE_DATA_WIDTH(4), .INITIAL_RUN(0)) dut (
    .ap_clk(clk), .ap_rst(rst),
    .s_axi_control_awvalid(awvalid), .s_axi_control_awready(awready),
    .s_axi_control_awaddr(awaddr),
    .s_axi_control_wvalid(wvalid), .s_axi_control_wready(wready),
    .s_axi_control_wdata(wdata), .s_axi_control_wstrb(wstrb),
    .s_axi_control_bvalid(bvalid), .s_axi_control_bready(bready),
    .s_axi_control_bresp(bresp),
    .s_axi_control_arvalid(arvalid), .s_axi_control_arready(arready),
    .s_axi_control_araddr(araddr),
    .s_axi_control_rvalid(rvalid), .s_axi_control_rready(rready),
    .s_axi_control_rdata(rdata), .s_axi_control_rresp(rresp),
    .outstream_tdata(tdata), .outstream_tvalid(tvalid),
    .outstream_tready(tready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stream monitor: the handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (tvalid && tready && !rst) begin
      beat_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_beat", 64'(exp_q.size()), 64'd1);
      end else begin
        chk("beat", tdata, exp_q.pop_front());
      end
    end
  end

  task automatic wait_b();
    int k = 0;
    while (!bvalid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("bvalid", 64'(bvalid), 64'd1);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_write(input logic [15:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    wait_b();
  endtask

  task automatic axi_read(input logic [15:0] a, output logic [31:0] d);
    int k = 0;
    @(posedge clk); #1;
    arvalid = 1'b1; araddr = a;
    @(posedge clk); #1;
    arvalid = 1'b0;
    while (!rvalid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("rvalid", 64'(rvalid), 64'd1);
    d = rdata;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tdata", tdata, 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    axi_read(A_CTRL, rd);
    chk("rst_ctrl", 64'(rd), 64'd0);
    axi_read(16'h0040, rd);
    chk("unmapped_read", 64'(rd), 64'h0000_dead);

    // Four back-to-back beats from seed 0x10.
    tready = 1'b1;
    axi_write(A_BEATS, 32'd4);
    axi_write(A_GAP, 32'd0);
    axi_write(A_SEED, 32'h10);
    for (int i = 0; i < 4; i++) exp_q.push_back(64'h10 + 64'(i));
    beat_cyc_q.delete();
    axi_write(A_CTRL, 32'd1);
    drain("t1_drain");
    repeat (3) @(posedge clk);
    for (int i = 1; i < beat_cyc_q.size(); i++)
      chk("t1_b2b", 64'(beat_cyc_q[i] - beat_cyc_q[i-1]), 64'd1);
    exp_sent = exp_sent + 64'd4;
    axi_read(A_SENT_LO, rd);
    chk("t1_sent", 64'(rd), exp_sent);
    axi_read(A_STATUS, rd);
    chk("t1_status", 64'(rd), 64'd2);

    // Three beats with a two-cycle gap, restarted from DONE.
    axi_write(A_BEATS, 32'd3);
    axi_write(A_GAP, 32'd2);
    axi_write(A_SEED, 32'h100);
    for (int i = 0; i < 3; i++) exp_q.push_back(64'h100 + 64'(i));
    beat_cyc_q.delete();
    axi_write(A_CTRL, 32'd1);
    drain("t2_drain");
    repeat (3) @(posedge clk);
    chk("t2_count", 64'(beat_cyc_q.size()), 64'd3);
    if (beat_cyc_q.size() == 3) begin
      chk("t2_gap0", 64'(beat_cyc_q[1] - beat_cyc_q[0]), 64'd3);
      chk("t2_gap1", 64'(beat_cyc_q[2] - beat_cyc_q[1]), 64'd3);
      chk("t2_span", 64'(beat_cyc_q[2] - beat_cyc_q[0] + 1), 64'd7);
    end
    exp_sent = exp_sent + 64'd3;
    axi_read(A_SENT_LO, rd);
    chk("t2_sent", 64'(rd), exp_sent);

    // Backpressure: the first beat must hold while tready is low.
    tready = 1'b0;
    axi_write(A_BEATS, 32'd2);
    axi_write(A_GAP, 32'd0);
    axi_write(A_SEED, 32'h55);
    exp_q.push_back(64'h55);
    exp_q.push_back(64'h56);
    axi_write(A_CTRL, 32'd1);
    n = 0;
    while (!tvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", 64'(tvalid), 64'd1);
      chk("t3_hold_data", tdata, 64'h55);
    end
    axi_read(A_SENT_LO, rd);
    chk("t3_sent_stalled", 64'(rd), exp_sent);
    @(posedge clk); #1;
    tready = 1'b1;
    drain("t3_drain");
    exp_sent = exp_sent + 64'd2;

    // Unbounded run, then stop under backpressure.
    exp_q.delete();
    for (int i = 0; i < 200; i++) exp_q.push_back(64'(i));
    axi_write(A_BEATS, 32'd0);
    axi_write(A_SEED, 32'd0);
    axi_write(A_CTRL, 32'd1);
    repeat (100) @(posedge clk);
    #1 tready = 1'b0;
    axi_write(A_CTRL, 32'd0);
    repeat (3) @(negedge clk);
    chk("t4_pending_valid", 64'(tvalid), 64'd1);
    n_before = exp_q.size();
    @(posedge clk); #1;
    tready = 1'b1;
    @(posedge clk); #1;
    tready = 1'b0;
    @(negedge clk);
    chk("t4_one_beat", 64'(exp_q.size()), 64'(n_before - 1));
    repeat (2) @(negedge clk);
    chk("t4_stopped", 64'(tvalid), 64'd0);
    n_sent = 200 - exp_q.size();
    exp_sent = exp_sent + 64'(n_sent);
    axi_read(A_SENT_LO, rd);
    axi_read(A_SENT_HI, rd_hi);
    chk("t4_sent_lo", 64'(rd), exp_sent);
    chk("t4_sent_hi", 64'(rd_hi), 64'd0);
    exp_q.delete();

    // Split-channel writes of clear: AW leads by three cycles, then W leads.
    @(posedge clk); #1;
    awvalid = 1'b1; awaddr = A_CTRL;
    @(posedge clk); #1;
    awvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("t5_no_early_b", 64'(bvalid), 64'd0);
    wvalid = 1'b1; wdata = 32'd2;
    @(posedge clk); #1;
    wvalid = 1'b0;
    wait_b();
    chk("t5_b_cleared", 64'(bvalid), 64'd0);
    wvalid = 1'b1; wdata = 32'd2;
    @(posedge clk); #1;
    wvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("t5_no_early_b2", 64'(bvalid), 64'd0);
    awvalid = 1'b1; awaddr = A_CTRL;
    @(posedge clk); #1;
    awvalid = 1'b0;
    wait_b();
    chk("t5_b_cleared2", 64'(bvalid), 64'd0);
    axi_read(A_CTRL, rd);
    chk("t5_ctrl", 64'(rd), 64'd2);
    axi_read(A_SENT_LO, rd);
    axi_read(A_SENT_HI, rd_hi);
    chk("t5_sent_lo", 64'(rd), 64'd0);
    chk("t5_sent_hi", 64'(rd_hi), 64'd0);
    chk("t5_idle", 64'(tvalid), 64'd0);

    // Asynchronous reset while a beat is pending.
    tready = 1'b0;
    axi_write(A_SEED, 32'h77);
    axi_write(A_CTRL, 32'd1);
    n = 0;
    while (!tvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6_sending", 64'(tvalid), 64'd1);
    #2 rst = 1'b1;
    #1 chk("t6_async_drop", 64'(tvalid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    axi_read(A_CTRL, rd);
    chk("t6_ctrl", 64'(rd), 64'd0);
    axi_read(A_SENT_LO, rd);
    chk("t6_sent", 64'(rd), 64'd0);
    axi_read(A_STATUS, rd);
    chk("t6_status", 64'(rd), 64'd0);
    repeat (3) @(negedge clk);
    chk("t6_idle", 64'(tvalid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/axis_traffic_gen.md
Name: axis_traffic_gen

Overview:
- Programmable AXI4-Stream source placed directly upstream of the stream measurer. It drives the measurer's input stream with a deterministic counting pattern so the measurer's counters can be checked against known values.
- Host control uses an AXI4-Lite slave with the same register style and control codes as the measurer: 1 = start, 0 = stop, 2 = clear.
- Beat count, inter-beat gap and a seed are configurable. Sent-beat count and status are readable.

Parameters:
DATA_WIDTH, 8, stream width in bytes (tdata is DATA_WIDTH*8 bits, at least 4).
STORE_DATA_WIDTH, 4, AXI-Lite data width in bytes (fixed at 4).
INITIAL_RUN, 0, control register reset value (1 = generate immediately after reset).

Ports:
ap_clk  in  1  single clock; all logic is on its rising edge.
ap_rst  in  1  asynchronous, active-high reset.
s_axi_control_awvalid/awready  in/out  1  write-address handshake.
s_axi_control_awaddr  in  16  byte write address.
s_axi_control_wvalid/wready  in/out  1  write-data handshake.
s_axi_control_wdata  in  32  write data.
s_axi_control_wstrb  in  4  ignored; full-word writes only.
s_axi_control_bvalid/bready  out/in  1  write response.
s_axi_control_bresp  out  2  always 2'b00.
s_axi_control_arvalid/arready  in/out  1  read-address handshake.
s_axi_control_araddr  in  16  byte read address.
s_axi_control_rvalid/rready  out/in  1  read-data handshake.
s_axi_control_rdata  out  32  read data.
s_axi_control_rresp  out  2  always 2'b00.
outstream_tdata  out  DATA_WIDTH*8  generated beat.
outstream_tvalid  out  1  beat valid.
outstream_tready  in  1  downstream ready (the measurer's input).

Behaviour:
Registers (byte offsets):
- 0x10 CONTROL (RW): 1 = start, 0 = stop, 2 = clear.
- 0x14 BEATS (RW): beats per run; 0 = unbounded.
- 0x18 GAP (RW): idle cycles inserted after each accepted beat.
- 0x1C SEED (RW): initial pattern value.
- 0x20 SENT_LO (RO) and 0x24 SENT_HI (RO): 64-bit count of accepted beats.
- 0x28 STATUS (RO): bit0 = busy (SEND or GAP), bit1 = done.
- Unmapped reads return 32'hdead. Unmapped writes are acknowledged and have no effect.

Reset values:
- CONTROL = INITIAL_RUN; BEATS = 0; GAP = 0; SEED = 0.
- SENT = 0; pattern counter = 0; state = IDLE.
- tvalid = 0, tdata = 0, bvalid = 0, rvalid = 0, rdata = 0.

AXI-Lite write:
- awready and wready are constant 1.
- If AW and W arrive in the same cycle, awaddr is used directly.
- If AW arrives first, its address is latched. If W arrives first, its data is latched. The write commits when the other channel arrives.
- bvalid rises the cycle after the commit and holds until bready.
- While bvalid is high and bready is low, a new commit still happens and bvalid stays high (no response counting).

AXI-Lite read:
- arready = !rvalid.
- rdata and rvalid are registered one cycle after the AR handshake. rvalid holds until rready.
- SENT_LO read snapshots SENT_HI into a shadow register. A later SENT_HI read returns the shadow, giving a coherent 64-bit read.

FSM states: IDLE, SEND, GAP, DONE.
- IDLE: when CONTROL == 1, load pattern = SEED, clear the run beat counter, go to SEND.
- SEND:
  - tvalid = 1 and tdata = pattern, zero-extended to DATA_WIDTH*8.
  - tdata and tvalid stay stable until tready.
  - On handshake: pattern += 1 (wraps at 2^32), SENT += 1 (64-bit, wraps), run counter += 1.
  - After the handshake: if BEATS != 0 and run counter == BEATS, go to DONE. Else if GAP != 0, go to GAP with gap counter = GAP. Else stay in SEND, so back-to-back beats at one per cycle are possible.
- GAP: tvalid = 0. Decrement the counter each cycle. Return to SEND in the cycle after it reaches 1.
- DONE: tvalid = 0, status done = 1. A new write of 1 to CONTROL, or rewriting 1, restarts from IDLE behaviour (reload SEED). Writing 0 or 2 goes to IDLE.
- Stop (CONTROL becomes 0) while in SEND with tvalid high: the pending beat must complete its handshake first, then go to IDLE. In GAP, go to IDLE immediately.
- Clear (CONTROL = 2):
  - Zeroes SENT and the pattern counter. Applies the same pending-beat rule as stop, then IDLE.
  - CONTROL holds 2 until rewritten.
  - If a beat completes in the same cycle as clear, the clear wins: SENT = 0.
- Register changes while running: BEATS and GAP changes take effect at the next comparison/load. SEED changes take effect only at the next start.
- Asynchronous reset mid-transfer: tvalid drops immediately and all state returns to its reset values.

Test Plan:
- BEATS = 4, GAP = 0, SEED = 0x10, start, tready = 1 -> tdata 0x10, 0x11, 0x12, 0x13 on 4 consecutive cycles; SENT = 4; STATUS = 0b10.
- BEATS = 3, GAP = 2, tready = 1 -> valid beats separated by exactly 2 idle cycles; total span 7 cycles from the first tvalid.
- BEATS = 2, tready held low for 5 cycles -> tvalid = 1 with tdata stable at the SEED value throughout; no increments until tready rises.
- BEATS = 0, run 100 cycles, then write stop while tready = 0 -> tvalid holds until one handshake, then 0; SENT_LO/SENT_HI read coherently (e.g., 100, 0).
- AW before W (3-cycle separation), then W before AW, each writing 2 -> SENT = 0, one bvalid per write, and a CONTROL read returns 2.
- Assert ap_rst during SEND with tvalid = 1 -> tvalid = 0 in the same cycle; a read of CONTROL after reset returns INITIAL_RUN.
